regfile_write_sequencer: RTL and testbench
==========================================

# regfile_write_sequencer

Owns the register file's single write port. Arbitrates between the pipeline writeback stage and the multi-cycle divider, which returns quotient and remainder together. The pipeline has priority. Divider results are buffered and written back as two sequential single-port writes: quotient to R29, then remainder to R30. The block sits between writeback/divider and the register file, and exports pending flags plus a stall request to the hazard unit.

## Interface
- QUO_REG, default 29: destination register index for the quotient.
- REM_REG, default 30: destination register index for the remainder.
- STARVE_LIMIT, default 4: consecutive lost arbitration cycles before a stall is requested.
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- WbRegWrite  in  1  pipeline write request this cycle.
- WbWriteRegister  in  5  pipeline destination.
- WbWriteData  in  32  pipeline data.
- DivValid  in  1  divider result available; held until accepted.
- DivReady  out  1  sequencer can accept a divider result.
- Quotient, Remainder  in  32 each  divider results.
- RegWrite  out  1  register-file write enable (registered).
- WriteRegister  out  5  register-file write address (registered).
- WriteData  out  32  register-file write data (registered).
- QuoPending, RemPending  out  1 each  buffered quotient/remainder not yet written.
- StallReq  out  1  hazard unit must hold WbRegWrite=0 the next cycle.

## Operation
- FSM states:
  - IDLE: buffer empty.
  - WR_QUO: quotient (and remainder) pending.
  - WR_REM: only remainder pending.
- DivReady = (state==IDLE). Acceptance happens on DivValid && DivReady.
  - Both values are captured, both pending bits are set, and the FSM moves to WR_QUO.
  - Acceptance is not blocked by a same-cycle pipeline write.
- Per-cycle arbitration, evaluated on the current-cycle inputs and state:
  - Effective pipeline write = WbRegWrite && WbWriteRegister!=0. A write to R0 is dropped and does not consume the port.
  - If there is an effective pipeline write, it wins. Pipeline address/data are registered to the outputs and RegWrite=1.
  - Otherwise, in WR_QUO: write Quotient to QUO_REG, clear QuoPending, go to WR_REM.
  - Otherwise, in WR_REM: write Remainder to REM_REG, clear RemPending, go to IDLE.
  - Otherwise: RegWrite=0, and WriteRegister/WriteData hold their previous values.
- Cancellation (the pipeline value is newer in program order):
  - An effective pipeline write to QUO_REG while QuoPending clears QuoPending; from WR_QUO the FSM goes to WR_REM.
  - A pipeline write to REM_REG while RemPending clears RemPending.
  - If both pending bits end up clear, the next state is IDLE.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle a pending entry exists and a pipeline write wins.
  - Cleared when a pending write issues or the FSM is in IDLE.
  - StallReq is registered, set when the counter reaches STARVE_LIMIT, and held until the next pending write issues.
- No arithmetic on data. Values pass through unmodified at 32 bits.

## Timing
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, QuoPending=0, RemPending=0, StallReq=0, state=IDLE, DivReady=1, counter=0.
- Reset mid-sequence discards buffered results. No partial write occurs after Reset.
- Pipeline write latency: request at cycle N gives RegWrite=1 at cycle N+1.
- Divider, uncontended: accepted at N, quotient RegWrite at N+2, remainder at N+3, DivReady=1 again at N+3.
- Each contended cycle delays the pending sequence by one.
- Pending flags reflect registered state. They are set the cycle after acceptance and cleared the cycle after the write is driven.
- Simultaneous acceptance and pipeline write at N: the pipeline write appears at N+1 and the quotient at N+2.

## Structure
- Shared package regfile_seq_pkg holds:
  - the state enum (IDLE, WR_QUO, WR_REM);
  - the default QUO_REG/REM_REG constants (29/30);
  - the register-index width (5) and data width (32).
- No sub-module is required. FSM, buffer and starvation counter live in one module.

## Test plan
- Pipeline only: WbRegWrite=1, reg 8, data 0x1234 at cycle 3 -> RegWrite=1, WriteRegister=8, WriteData=0x1234 at cycle 4. A write to reg 0 -> RegWrite stays 0.
- Divider uncontended: DivValid with Q=7, R=3 at cycle 5 -> (29,7) at cycle 7, (30,3) at cycle 8. DivReady low cycles 6-7, high at cycle 8.
- Contention: divider accepted at cycle 5, pipeline writes reg 9 on cycles 5-6 -> reg 9 writes at cycles 6-7, quotient at cycle 8, remainder at cycle 9.
- Cancellation: QuoPending set, pipeline writes reg 29 = 0xAA -> only 0xAA is written to R29, then the remainder to R30 the following free cycle. Write both 29 and 30 -> FSM returns to IDLE with no divider writes.
- Starvation: STARVE_LIMIT=4, pipeline writes every cycle while pending -> StallReq=1 after 4 lost cycles. With Wb held 0, the quotient writes and StallReq drops the same cycle the write is driven.
- Reset mid-sequence: assert Reset the cycle after acceptance -> no R29/R30 write, all outputs at reset values, DivReady=1 the cycle after Reset deasserts.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file write sequencer.
package regfile_seq_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned QUO_REG_DEF = 29;
  localparam int unsigned REM_REG_DEF = 30;

  // Divider buffer state: which halves of the result still need the port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_QUO = 2'd1,
    WR_REM = 2'd2
  } seq_state_e;

  // One register-file write: destination index plus data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_write_sequencer.sv
// Owns the register file write port: pipeline writeback has priority, buffered
// divider results drain as quotient then remainder, and a stall is requested
// when the buffered results keep losing arbitration.
module regfile_write_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned QUO_REG      = QUO_REG_DEF,
  parameter int unsigned REM_REG      = REM_REG_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_reg_write,
  input  logic [REG_IDX_W-1:0] i_wb_write_register,
  input  logic [DATA_W-1:0]    i_wb_write_data,
  input  logic                 i_div_valid,
  output logic                 o_div_ready,
  input  logic [DATA_W-1:0]    i_quotient,
  input  logic [DATA_W-1:0]    i_remainder,
  output logic                 o_reg_write,
  output logic [REG_IDX_W-1:0] o_write_register,
  output logic [DATA_W-1:0]    o_write_data,
  output logic                 o_quo_pending,
  output logic                 o_rem_pending,
  output logic                 o_stall_req
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [REG_IDX_W-1:0] QUO_IDX   = REG_IDX_W'(QUO_REG);
  localparam logic [REG_IDX_W-1:0] REM_IDX   = REG_IDX_W'(REM_REG);

  seq_state_e         r_state;
  logic               r_quo_pend;
  logic               r_rem_pend;
  logic [DATA_W-1:0]  r_quo_data;
  logic [DATA_W-1:0]  r_rem_data;
  logic               r_reg_write;
  rf_wr_t             r_wr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_stall;
  logic               r_div_ready;

  seq_state_e         w_state_next;
  logic               w_quo_pend_next;
  logic               w_rem_pend_next;
  logic               w_reg_write_next;
  rf_wr_t             w_wr_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_stall_next;
  logic               w_pipe_eff;
  logic               w_accept;
  logic               w_issue;

  assign o_div_ready      = r_div_ready;
  assign o_reg_write      = r_reg_write;
  assign o_write_register = r_wr.addr;
  assign o_write_data     = r_wr.data;
  assign o_quo_pending    = r_quo_pend;
  assign o_rem_pending    = r_rem_pend;
  assign o_stall_req      = r_stall;

  // Arbitration, cancellation, buffer-state and starvation next-state logic.
  always_comb begin
    w_state_next     = r_state;
    w_quo_pend_next  = r_quo_pend;
    w_rem_pend_next  = r_rem_pend;
    w_reg_write_next = 1'b0;
    w_wr_next        = r_wr;
    w_cnt_next       = r_cnt;
    w_stall_next     = r_stall;
    w_issue          = 1'b0;
    w_pipe_eff       = i_wb_reg_write && (i_wb_write_register != '0);
    w_accept         = i_div_valid && (r_state == IDLE);

    if (w_pipe_eff) begin
      w_reg_write_next = 1'b1;
      w_wr_next.addr   = i_wb_write_register;
      w_wr_next.data   = i_wb_write_data;
      // A newer pipeline value supersedes the buffered one for the same register.
      if (r_quo_pend && (i_wb_write_register == QUO_IDX)) w_quo_pend_next = 1'b0;
      if (r_rem_pend && (i_wb_write_register == REM_IDX)) w_rem_pend_next = 1'b0;
    end else begin
      unique case (r_state)
        WR_QUO: begin
          w_reg_write_next = 1'b1;
          w_wr_next.addr   = QUO_IDX;
          w_wr_next.data   = r_quo_data;
          w_quo_pend_next  = 1'b0;
          w_issue          = 1'b1;
        end
        WR_REM: begin
          w_reg_write_next = 1'b1;
          w_wr_next.addr   = REM_IDX;
          w_wr_next.data   = r_rem_data;
          w_rem_pend_next  = 1'b0;
          w_issue          = 1'b1;
        end
        default: ;
      endcase
    end

    if (w_accept) begin
      w_quo_pend_next = 1'b1;
      w_rem_pend_next = 1'b1;
    end

    if (w_quo_pend_next)      w_state_next = WR_QUO;
    else if (w_rem_pend_next) w_state_next = WR_REM;
    else                      w_state_next = IDLE;

    if (w_issue || (r_state == IDLE) || (w_state_next == IDLE)) begin
      w_cnt_next = '0;
    end else if (w_pipe_eff && (r_cnt != CNT_LIMIT)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end

    if (w_issue || (w_state_next == IDLE)) begin
      w_stall_next = 1'b0;
    end else if (w_cnt_next == CNT_LIMIT) begin
      w_stall_next = 1'b1;
    end
  end

  // State, buffer and registered write-port outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_quo_pend  <= 1'b0;
      r_rem_pend  <= 1'b0;
      r_quo_data  <= '0;
      r_rem_data  <= '0;
      r_reg_write <= 1'b0;
      r_wr        <= '0;
      r_cnt       <= '0;
      r_stall     <= 1'b0;
      r_div_ready <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_quo_pend  <= w_quo_pend_next;
      r_rem_pend  <= w_rem_pend_next;
      r_reg_write <= w_reg_write_next;
      r_wr        <= w_wr_next;
      r_cnt       <= w_cnt_next;
      r_stall     <= w_stall_next;
      r_div_ready <= (w_state_next == IDLE);
      if (w_accept) begin
        r_quo_data <= i_quotient;
        r_rem_data <= i_remainder;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_regfile_write_sequencer;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dv;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        o_div_ready;
  logic        o_reg_write;
  logic [4:0]  o_write_register;
  logic [31:0] o_write_data;
  logic        o_quo_pending;
  logic        o_rem_pending;
  logic        o_stall_req;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of buffered writes still owed to the port.
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  int          m_cnt;
  bit          m_stall;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  regfile_write_sequencer #(
    .QUO_REG(29), .REM_REG(30), .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_wb_reg_write(wb_we), .i_wb_write_register(wb_addr), .i_wb_write_data(wb_data),
    .i_div_valid(dv), .o_div_ready(o_div_ready),
    .i_quotient(quo), .i_remainder(rem),
    .o_reg_write(o_reg_write), .o_write_register(o_write_register), .o_write_data(o_write_data),
    .o_quo_pending(o_quo_pending), .o_rem_pending(o_rem_pending), .o_stall_req(o_stall_req)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    dv = 1'b0; quo = 32'd0; rem = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    mq_addr.delete(); mq_data.delete();
    m_cnt = 0; m_stall = 0; e_we = 0; e_addr = 5'd0; e_data = 32'd0;
  endtask

  function automatic bit m_has(input logic [4:0] a);
    foreach (mq_addr[i]) if (mq_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one cycle of the given inputs.
  task automatic model_step();
    bit had;
    bit popped;
    bit pipe;
    had    = (mq_addr.size() != 0);
    popped = 1'b0;
    pipe   = wb_we && (wb_addr != 5'd0);
    if (pipe) begin
      e_we = 1'b1; e_addr = wb_addr; e_data = wb_data;
      for (int i = mq_addr.size() - 1; i >= 0; i--) begin
        if (mq_addr[i] == wb_addr) begin
          mq_addr.delete(i); mq_data.delete(i);
        end
      end
    end else if (had) begin
      e_we = 1'b1;
      e_addr = mq_addr.pop_front();
      e_data = mq_data.pop_front();
      popped = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    if (dv && !had) begin
      mq_addr.push_back(5'd29); mq_data.push_back(quo);
      mq_addr.push_back(5'd30); mq_data.push_back(rem);
    end
    if (mq_addr.size() == 0 || popped) begin
      m_cnt = 0; m_stall = 0;
    end else if (pipe && had) begin
      if (m_cnt < LIMIT) m_cnt++;
      if (m_cnt == LIMIT) m_stall = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    dv = 1'b1; quo = 32'h1; rem = 32'h2;
    cyc(); cyc();
    total++;
    if (o_reg_write !== 1'b0 || o_write_register !== 5'd0 || o_write_data !== 32'd0 ||
        o_quo_pending !== 1'b0 || o_rem_pending !== 1'b0 || o_stall_req !== 1'b0 || o_div_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: we=%0b reg=%0d data=%h qp=%0b rp=%0b st=%0b rdy=%0b, want 0/0/0/0/0/0/1",
               o_reg_write, o_write_register, o_write_data, o_quo_pending, o_rem_pending, o_stall_req, o_div_ready);
    end
    do_reset();
  endtask

  task automatic test_pipeline();
    do_reset();
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd8 || o_write_data !== 32'h1234) begin
      bad++;
      $display("FAIL pipe_write: got %0b/%0d/%h want 1/8/00001234", o_reg_write, o_write_register, o_write_data);
    end
    wb_addr = 5'd0; wb_data = 32'h5555;
    cyc();
    total++;
    if (o_reg_write !== 1'b0 || o_write_register !== 5'd8 || o_write_data !== 32'h1234) begin
      bad++;
      $display("FAIL pipe_r0_drop: got %0b/%0d/%h want 0/8/00001234", o_reg_write, o_write_register, o_write_data);
    end
    idle_inputs();
  endtask

  task automatic test_divider();
    do_reset();
    dv = 1'b1; quo = 32'd7; rem = 32'd3;
    cyc();
    dv = 1'b0;
    total++;
    if (o_reg_write !== 1'b0 || o_div_ready !== 1'b0 || o_quo_pending !== 1'b1 || o_rem_pending !== 1'b1) begin
      bad++;
      $display("FAIL div_accept: we=%0b rdy=%0b qp=%0b rp=%0b want 0/0/1/1", o_reg_write, o_div_ready, o_quo_pending, o_rem_pending);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd29 || o_write_data !== 32'd7 || o_div_ready !== 1'b0 || o_quo_pending !== 1'b0) begin
      bad++;
      $display("FAIL div_quo: got %0b/%0d/%h rdy=%0b qp=%0b want 1/29/7 rdy=0 qp=0", o_reg_write, o_write_register, o_write_data, o_div_ready, o_quo_pending);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd30 || o_write_data !== 32'd3 || o_div_ready !== 1'b1 || o_rem_pending !== 1'b0) begin
      bad++;
      $display("FAIL div_rem: got %0b/%0d/%h rdy=%0b rp=%0b want 1/30/3 rdy=1 rp=0", o_reg_write, o_write_register, o_write_data, o_div_ready, o_rem_pending);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b0 || o_write_register !== 5'd30 || o_write_data !== 32'd3) begin
      bad++;
      $display("FAIL div_hold: got %0b/%0d/%h want 0/30/3", o_reg_write, o_write_register, o_write_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dv = 1'b1; quo = 32'hA1; rem = 32'hB2;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h900;
    cyc();
    dv = 1'b0; wb_data = 32'h901;
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd9 || o_write_data !== 32'h900 || o_quo_pending !== 1'b1) begin
      bad++;
      $display("FAIL contend_1: got %0b/%0d/%h qp=%0b want 1/9/900 qp=1", o_reg_write, o_write_register, o_write_data, o_quo_pending);
    end
    cyc();
    wb_we = 1'b0;
    total++;
    if (o_write_register !== 5'd9 || o_write_data !== 32'h901) begin
      bad++;
      $display("FAIL contend_2: got %0d/%h want 9/901", o_write_register, o_write_data);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd29 || o_write_data !== 32'hA1) begin
      bad++;
      $display("FAIL contend_quo: got %0b/%0d/%h want 1/29/a1", o_reg_write, o_write_register, o_write_data);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd30 || o_write_data !== 32'hB2 || o_div_ready !== 1'b1) begin
      bad++;
      $display("FAIL contend_rem: got %0b/%0d/%h rdy=%0b want 1/30/b2 rdy=1", o_reg_write, o_write_register, o_write_data, o_div_ready);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    dv = 1'b1; quo = 32'h11; rem = 32'h22;
    cyc();
    dv = 1'b0; wb_we = 1'b1; wb_addr = 5'd29; wb_data = 32'hAA;
    cyc();
    wb_we = 1'b0;
    total++;
    if (o_write_register !== 5'd29 || o_write_data !== 32'hAA || o_quo_pending !== 1'b0 || o_rem_pending !== 1'b1) begin
      bad++;
      $display("FAIL cancel_quo: got %0d/%h qp=%0b rp=%0b want 29/aa qp=0 rp=1", o_write_register, o_write_data, o_quo_pending, o_rem_pending);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd30 || o_write_data !== 32'h22 || o_div_ready !== 1'b1) begin
      bad++;
      $display("FAIL cancel_rem_after: got %0b/%0d/%h rdy=%0b want 1/30/22 rdy=1", o_reg_write, o_write_register, o_write_data, o_div_ready);
    end
    dv = 1'b1; quo = 32'h33; rem = 32'h44;
    cyc();
    dv = 1'b0; wb_we = 1'b1; wb_addr = 5'd29; wb_data = 32'h55;
    cyc();
    wb_addr = 5'd30; wb_data = 32'h66;
    cyc();
    wb_we = 1'b0;
    total++;
    if (o_write_register !== 5'd30 || o_write_data !== 32'h66 || o_quo_pending !== 1'b0 || o_rem_pending !== 1'b0 || o_div_ready !== 1'b1) begin
      bad++;
      $display("FAIL cancel_both: got %0d/%h qp=%0b rp=%0b rdy=%0b want 30/66/0/0/1", o_write_register, o_write_data, o_quo_pending, o_rem_pending, o_div_ready);
    end
    cyc();
    total++;
    if (o_reg_write !== 1'b0) begin
      bad++;
      $display("FAIL cancel_both_nowrite: got we=%0b want 0", o_reg_write);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    dv = 1'b1; quo = 32'hC0; rem = 32'hC1;
    cyc();
    dv = 1'b0; wb_we = 1'b1; wb_addr = 5'd5;
    for (int k = 1; k <= 4; k++) begin
      wb_data = 32'(k);
      cyc();
      total++;
      if (o_stall_req !== ((k == 4) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL starve_lost%0d: stall=%0b want %0b", k, o_stall_req, (k == 4));
      end
    end
    wb_we = 1'b0;
    cyc();
    total++;
    if (o_reg_write !== 1'b1 || o_write_register !== 5'd29 || o_write_data !== 32'hC0 || o_stall_req !== 1'b0) begin
      bad++;
      $display("FAIL starve_release: got %0b/%0d/%h stall=%0b want 1/29/c0 stall=0", o_reg_write, o_write_register, o_write_data, o_stall_req);
    end
    cyc();
    total++;
    if (o_write_register !== 5'd30 || o_write_data !== 32'hC1) begin
      bad++;
      $display("FAIL starve_rem: got %0d/%h want 30/c1", o_write_register, o_write_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dv = 1'b1; quo = 32'hE0; rem = 32'hE1;
    cyc();
    dv = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (o_reg_write !== 1'b0 || o_write_register !== 5'd0 || o_write_data !== 32'd0 ||
        o_quo_pending !== 1'b0 || o_rem_pending !== 1'b0 || o_stall_req !== 1'b0 || o_div_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_values: we=%0b reg=%0d data=%h qp=%0b rp=%0b st=%0b rdy=%0b",
               o_reg_write, o_write_register, o_write_data, o_quo_pending, o_rem_pending, o_stall_req, o_div_ready);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (o_reg_write !== 1'b0 || o_div_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_mid_quiet%0d: we=%0b rdy=%0b want 0/1", k, o_reg_write, o_div_ready);
      end
    end
  endtask

  task automatic test_random();
    bit hold;
    bit acc;
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        dv = ($urandom_range(0, 3) == 0);
        quo = $urandom; rem = $urandom;
      end
      wb_we = m_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 4))
        0: wb_addr = 5'd0;
        1: wb_addr = 5'd29;
        2: wb_addr = 5'd30;
        default: wb_addr = 5'($urandom_range(1, 31));
      endcase
      wb_data = $urandom;
      acc = dv && (mq_addr.size() == 0);
      model_step();
      hold = dv && !acc;
      cyc();
      total++;
      if (o_reg_write !== e_we || o_write_register !== e_addr || o_write_data !== e_data) begin
        bad++;
        $display("FAIL rand_write@%0d: got %0b/%0d/%h want %0b/%0d/%h", n,
                 o_reg_write, o_write_register, o_write_data, e_we, e_addr, e_data);
      end
      total++;
      if (o_quo_pending !== m_has(5'd29) || o_rem_pending !== m_has(5'd30) ||
          o_stall_req !== m_stall || o_div_ready !== (mq_addr.size() == 0)) begin
        bad++;
        $display("FAIL rand_flags@%0d: qp=%0b rp=%0b st=%0b rdy=%0b want %0b/%0b/%0b/%0b", n,
                 o_quo_pending, o_rem_pending, o_stall_req, o_div_ready,
                 m_has(5'd29), m_has(5'd30), m_stall, (mq_addr.size() == 0));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_pipeline();
    test_divider();
    test_back_to_back();
    test_cancel();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
